// File: rtl/gate_vector_sequencer.sv
// Stimulus/check stage for the two-input gate block.
// Walks {a,b} through 00,01,10,11, holds each vector for SETTLE_CYCLES
// cycles, then compares the eight gate results against locally computed
// expected values in a one-cycle CHECK. Results are accumulated into a
// sticky per-gate mismatch mask and a saturating failing-vector count.
//
// state  | meaning
// IDLE   | waiting for start_in; results of the last run are held
// SETTLE | vector driven, gate outputs ignored while counter runs down
// CHECK  | gate outputs compared, vector advanced
// DONE   | one-cycle completion pulse, pass verdict visible
module gate_vector_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             xor_in,
  input  logic             anot_in,
  input  logic             bnot_in,
  input  logic             nand_in,
  input  logic             nor_in,
  input  logic             xnor_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [7:0]       fail_mask_out
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_vec, w_vec_nxt;
  logic [SET_W-1:0]   r_settle, w_settle_nxt;
  logic [LOOP_W-1:0]  r_loop, w_loop_nxt;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic [7:0]         r_mask, w_mask_nxt;
  logic               r_pass, w_pass_nxt;

  logic               w_a;
  logic               w_b;
  logic [7:0]         w_expected;
  logic [7:0]         w_actual;
  logic [7:0]         w_mismatch;
  logic               w_any_mismatch;
  logic [ERR_W-1:0]   w_err_checked;

  // Vector index doubles as the stimulus: bit 1 is A, bit 0 is B.
  assign w_a = r_vec[1];
  assign w_b = r_vec[0];

  // Bit order matches fail_mask_out: and, or, xor, anot, bnot, nand, nor, xnor.
  assign w_expected = {w_a & w_b, w_a | w_b, w_a ^ w_b, ~w_a, ~w_b,
                       ~(w_a & w_b), ~(w_a | w_b), ~(w_a ^ w_b)};
  assign w_actual   = {and_in, or_in, xor_in, anot_in, bnot_in,
                       nand_in, nor_in, xnor_in};
  assign w_mismatch     = w_expected ^ w_actual;
  assign w_any_mismatch = |w_mismatch;

  // Count after this CHECK; the pass verdict is taken from this value so a
  // failure on the final vector is already reflected when DONE is entered.
  assign w_err_checked = (w_any_mismatch && (r_err != ERR_MAX)) ?
                         (r_err + ERR_W'(1)) : r_err;

  // State register and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_vec    <= 2'b00;
      r_settle <= '0;
      r_loop   <= '0;
      r_err    <= '0;
      r_mask   <= 8'h00;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_settle <= w_settle_nxt;
      r_loop   <= w_loop_nxt;
      r_err    <= w_err_nxt;
      r_mask   <= w_mask_nxt;
      r_pass   <= w_pass_nxt;
    end
  end

  // Next-state and next-datapath logic; every register holds by default.
  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_settle_nxt = r_settle;
    w_loop_nxt   = r_loop;
    w_err_nxt    = r_err;
    w_mask_nxt   = r_mask;
    w_pass_nxt   = r_pass;

    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_state_nxt  = ST_SETTLE;
          w_vec_nxt    = 2'b00;
          w_loop_nxt   = '0;
          w_settle_nxt = SET_LOAD;
          w_err_nxt    = '0;
          w_mask_nxt   = 8'h00;
          w_pass_nxt   = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (r_settle == '0) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_settle_nxt = r_settle - SET_W'(1);
        end
      end

      ST_CHECK: begin
        w_mask_nxt = r_mask | w_mismatch;
        w_err_nxt  = w_err_checked;
        if (r_vec == 2'b11) begin
          if (r_loop == LOOP_LAST) begin
            // Final vector: A/B stay at 1,1 through DONE.
            w_state_nxt = ST_DONE;
            w_pass_nxt  = (w_err_checked == '0);
          end else begin
            w_state_nxt  = ST_SETTLE;
            w_vec_nxt    = 2'b00;
            w_loop_nxt   = r_loop + LOOP_W'(1);
            w_settle_nxt = SET_LOAD;
          end
        end else begin
          w_state_nxt  = ST_SETTLE;
          w_vec_nxt    = r_vec + 2'b01;
          w_settle_nxt = SET_LOAD;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_vec_nxt   = 2'b00;
        w_loop_nxt  = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_vec_nxt   = 2'b00;
        w_loop_nxt  = '0;
      end
    endcase
  end

  // Outputs come straight from registers or a decode of the state register.
  assign a_out         = w_a;
  assign b_out         = w_b;
  assign busy_out      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done_out      = (r_state == ST_DONE);
  assign pass_out      = r_pass;
  assign err_count_out = r_err;
  assign fail_mask_out = r_mask;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: a behavioural gate block with selectable
// faults feeds each DUT instance; run results are compared with hand-derived
// expectations from tables and a few directed sequences.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: ERR_W=2, LOOPS=2.
  logic       start0 = 1'b0, start1 = 1'b0;
  int         mode0 = 0, mode1 = 0;
  logic       glitch = 1'b0;
  logic [7:0] g0, g1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] err0;
  logic [1:0] err1;
  logic [7:0] mask0, mask1;

  // Gate block model; mode 1 xor stuck-0, 2 and glitch, 3 anot stuck-1, 4 all inverted.
  function automatic logic [7:0] gates(input logic a, input logic b,
                                       input int mode, input logic gl);
    logic [7:0] g;
    g = {a & b, a | b, a ^ b, ~a, ~b, ~(a & b), ~(a | b), ~(a ^ b)};
    case (mode)
      1: g[5] = 1'b0;
      2: if (gl) g[7] = ~g[7];
      3: g[4] = 1'b1;
      4: g = ~g;
      default: ;
    endcase
    return g;
  endfunction

  assign g0 = gates(a0, b0, mode0, glitch);
  assign g1 = gates(a1, b1, mode1, glitch);

  gate_vector_sequencer dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start0),
    .and_in(g0[7]), .or_in(g0[6]), .xor_in(g0[5]), .anot_in(g0[4]),
    .bnot_in(g0[3]), .nand_in(g0[2]), .nor_in(g0[1]), .xnor_in(g0[0]),
    .a_out(a0), .b_out(b0), .busy_out(busy0), .done_out(done0),
    .pass_out(pass0), .err_count_out(err0), .fail_mask_out(mask0)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1),
    .and_in(g1[7]), .or_in(g1[6]), .xor_in(g1[5]), .anot_in(g1[4]),
    .bnot_in(g1[3]), .nand_in(g1[2]), .nor_in(g1[1]), .xnor_in(g1[0]),
    .a_out(a1), .b_out(b1), .busy_out(busy1), .done_out(done1),
    .pass_out(pass1), .err_count_out(err1), .fail_mask_out(mask1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Per-cycle samples of the most recent run (cycle 1 = first cycle after start edge).
  logic       s_a[0:63], s_b[0:63], s_busy[0:63], s_done[0:63], s_pass[0:63];
  logic [3:0] s_err[0:63];
  logic [7:0] s_mask[0:63];
  int         done_first, done_cnt;
  logic [3:0] err_at;
  logic [7:0] mask_at;
  logic       pass_at;

  // Start mode 0: single pulse; 1: extra pulses while busy; 2: start held through cycle 14.
  task automatic do_run(input bit sel, input int smode, input int max_cyc);
    bit st;
    done_first = -1;
    done_cnt   = 0;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      case (smode)
        1: st = (c <= 12) && (c % 2 == 0);
        2: st = (c <= 14);
        default: st = 1'b0;
      endcase
      if (sel) start1 = st; else start0 = st;
      glitch    = (c % 3 != 0);
      s_a[c]    = sel ? a1 : a0;
      s_b[c]    = sel ? b1 : b0;
      s_busy[c] = sel ? busy1 : busy0;
      s_done[c] = sel ? done1 : done0;
      s_pass[c] = sel ? pass1 : pass0;
      s_err[c]  = sel ? {2'b00, err1} : err0;
      s_mask[c] = sel ? mask1 : mask0;
      if (s_done[c]) begin
        done_cnt++;
        if (done_first < 0) begin
          done_first = c;
          err_at  = s_err[c];
          mask_at = s_mask[c];
          pass_at = s_pass[c];
        end
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    glitch = 1'b0;
  endtask

  typedef struct {
    int   cyc;
    logic a;
    logic b;
    logic busy;
    logic done;
  } cyc_vec_t;

  typedef struct {
    int         mode;
    logic [3:0] err;
    logic [7:0] mask;
    logic       pass;
  } scen_t;

  cyc_vec_t cyc_tbl[14];
  scen_t    scen_tbl[5];

  task automatic apply_cycle_table(input string tag);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s c%0d a", tag, cyc_tbl[i].cyc), 32'(s_a[cyc_tbl[i].cyc]), 32'(cyc_tbl[i].a));
      chk($sformatf("%s c%0d b", tag, cyc_tbl[i].cyc), 32'(s_b[cyc_tbl[i].cyc]), 32'(cyc_tbl[i].b));
      chk($sformatf("%s c%0d busy", tag, cyc_tbl[i].cyc), 32'(s_busy[cyc_tbl[i].cyc]), 32'(cyc_tbl[i].busy));
      chk($sformatf("%s c%0d done", tag, cyc_tbl[i].cyc), 32'(s_done[cyc_tbl[i].cyc]), 32'(cyc_tbl[i].done));
    end
  endtask

  initial begin
    // Default timing: each vector 3 cycles, done in cycle 13, back to 00 in cycle 14.
    cyc_tbl[0]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0};
    cyc_tbl[1]  = '{2,  1'b0, 1'b0, 1'b1, 1'b0};
    cyc_tbl[2]  = '{3,  1'b0, 1'b0, 1'b1, 1'b0};
    cyc_tbl[3]  = '{4,  1'b0, 1'b1, 1'b1, 1'b0};
    cyc_tbl[4]  = '{5,  1'b0, 1'b1, 1'b1, 1'b0};
    cyc_tbl[5]  = '{6,  1'b0, 1'b1, 1'b1, 1'b0};
    cyc_tbl[6]  = '{7,  1'b1, 1'b0, 1'b1, 1'b0};
    cyc_tbl[7]  = '{8,  1'b1, 1'b0, 1'b1, 1'b0};
    cyc_tbl[8]  = '{9,  1'b1, 1'b0, 1'b1, 1'b0};
    cyc_tbl[9]  = '{10, 1'b1, 1'b1, 1'b1, 1'b0};
    cyc_tbl[10] = '{11, 1'b1, 1'b1, 1'b1, 1'b0};
    cyc_tbl[11] = '{12, 1'b1, 1'b1, 1'b1, 1'b0};
    cyc_tbl[12] = '{13, 1'b1, 1'b1, 1'b0, 1'b1};
    cyc_tbl[13] = '{14, 1'b0, 1'b0, 1'b0, 1'b0};

    scen_tbl[0] = '{0, 4'd0, 8'h00, 1'b1};
    scen_tbl[1] = '{1, 4'd2, 8'h20, 1'b0};
    scen_tbl[2] = '{2, 4'd0, 8'h00, 1'b1};
    scen_tbl[3] = '{3, 4'd2, 8'h10, 1'b0};
    scen_tbl[4] = '{4, 4'd4, 8'hFF, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst a0", 32'(a0), 0);
    chk("rst b0", 32'(b0), 0);
    chk("rst busy0", 32'(busy0), 0);
    chk("rst done0", 32'(done0), 0);
    chk("rst pass0", 32'(pass0), 0);
    chk("rst err0", 32'(err0), 0);
    chk("rst mask0", 32'(mask0), 0);
    chk("rst err1", 32'(err1), 0);
    chk("rst busy1", 32'(busy1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Correct gate model: full sequence timing.
    mode0 = 0;
    do_run(1'b0, 0, 16);
    apply_cycle_table("base");
    chk("base pass held c16", 32'(s_pass[16]), 1);

    // Fault scenarios on default instance.
    for (int i = 0; i < 5; i++) begin
      mode0 = scen_tbl[i].mode;
      do_run(1'b0, 0, 16);
      chk($sformatf("scen%0d done_cyc", i), 32'(done_first), 13);
      chk($sformatf("scen%0d done_cnt", i), 32'(done_cnt), 1);
      chk($sformatf("scen%0d err", i), 32'(err_at), 32'(scen_tbl[i].err));
      chk($sformatf("scen%0d mask", i), 32'(mask_at), 32'(scen_tbl[i].mask));
      chk($sformatf("scen%0d pass", i), 32'(pass_at), 32'(scen_tbl[i].pass));
      chk($sformatf("scen%0d err held", i), 32'(s_err[16]), 32'(scen_tbl[i].err));
      chk($sformatf("scen%0d mask held", i), 32'(s_mask[16]), 32'(scen_tbl[i].mask));
    end

    // Two loops, narrow saturating counter, everything inverted.
    mode1 = 4;
    do_run(1'b1, 0, 28);
    chk("sat done_cyc", 32'(done_first), 25);
    chk("sat done_cnt", 32'(done_cnt), 1);
    chk("sat err", 32'(err_at), 3);
    chk("sat mask", 32'(mask_at), 32'h00FF);
    chk("sat pass", 32'(pass_at), 0);
    chk("sat c12 ab", 32'({s_a[12], s_b[12]}), 3);
    chk("sat c13 ab", 32'({s_a[13], s_b[13]}), 0);
    chk("sat c24 ab", 32'({s_a[24], s_b[24]}), 3);
    mode1 = 0;

    // Start pulses while busy are ignored; a later start clears results.
    mode0 = 0;
    do_run(1'b0, 0, 16);
    chk("pre pass", 32'(pass_at), 1);
    mode0 = 1;
    do_run(1'b0, 1, 20);
    chk("busy-start done_cnt", 32'(done_cnt), 1);
    chk("busy-start done_cyc", 32'(done_first), 13);
    chk("busy-start pass cleared", 32'(s_pass[1]), 0);
    chk("busy-start err", 32'(err_at), 2);
    mode0 = 0;
    do_run(1'b0, 0, 16);
    chk("restart ab c1", 32'({s_a[1], s_b[1]}), 0);
    chk("restart err cleared", 32'(s_err[1]), 0);
    chk("restart mask cleared", 32'(s_mask[1]), 0);
    chk("restart pass", 32'(pass_at), 1);

    // Level-high start: second run begins from IDLE after DONE.
    do_run(1'b0, 2, 30);
    chk("level done_cnt", 32'(done_cnt), 2);
    chk("level done_cyc", 32'(done_first), 13);
    chk("level 2nd done", 32'(s_done[27]), 1);
    chk("level c15 ab", 32'({s_a[15], s_b[15]}), 0);

    // Reset during SETTLE of vector 10.
    mode0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("pre-rst ab", 32'({a0, b0}), 2);
    chk("pre-rst err", 32'(err0), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst ab", 32'({a0, b0}), 0);
    chk("mid-rst busy", 32'(busy0), 0);
    chk("mid-rst done", 32'(done0), 0);
    chk("mid-rst pass", 32'(pass0), 0);
    chk("mid-rst err", 32'(err0), 0);
    chk("mid-rst mask", 32'(mask0), 0);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done0 || busy0) seen++;
      end
      chk("post-rst idle", 32'(seen), 0);
    end
    mode0 = 0;
    do_run(1'b0, 0, 16);
    apply_cycle_table("post-rst");
    chk("post-rst pass", 32'(pass_at), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
